// File: rtl/step_phase_decoder_pkg.sv
// Shared phase/index table, idle pattern and decoder FSM encoding.
// The index-to-pattern lookup is the same mapping the driver side uses.
package step_phase_decoder_pkg;

    localparam logic [3:0] PHASE_IDLE = 4'b0000;

    // Half-step order; full-step wave drive uses the even entries only.
    localparam logic [3:0] PHASE_TBL [8] = '{
        4'b0001, 4'b0011, 4'b0010, 4'b0110,
        4'b0100, 4'b1100, 4'b1000, 4'b1001
    };

    typedef enum logic {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } state_t;

    function automatic logic [3:0] idx_to_phase(input logic [2:0] idx);
        return PHASE_TBL[idx];
    endfunction

endpackage

// File: rtl/step_phase_decoder_if.sv
// Coil-phase input, position clear and decoded step/position status.
interface step_phase_decoder_if #(parameter int POS_W = 16);
    logic [3:0]       phase_in;
    logic             clr_pos;
    logic             step_pulse;
    logic             dir;
    logic [POS_W-1:0] position;
    logic             locked;
    logic             err_pulse;
    logic             err_sticky;

    modport master (
        output phase_in, clr_pos,
        input  step_pulse, dir, position, locked, err_pulse, err_sticky
    );

    modport slave (
        input  phase_in, clr_pos,
        output step_pulse, dir, position, locked, err_pulse, err_sticky
    );
endinterface

// File: rtl/step_phase_decoder_phase_sync_filter.sv
// Two-flop synchronizer followed by a stability filter; emits a one-cycle
// acceptance when a new pattern has been seen STABLE_CYC times in a row.
module phase_sync_filter #(
    parameter int STABLE_CYC = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] phase_i,
    output logic       acc_valid_o,
    output logic [3:0] acc_pattern_o
);
    localparam int            CW      = $clog2(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC);

    logic [3:0]    sync1_q, sync2_q, cand_q, last_q, pat_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          acc_q;
    logic          match, hit;

    // The count saturates so a long-held pattern yields only one hit.
    always_comb begin
        match = (sync2_q == cand_q);
        cnt_d = cnt_q;
        if (!match)
            cnt_d = CW'(1);
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + CW'(1);
        hit = (cnt_d == CNT_MAX) && !(match && (cnt_q == CNT_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            pat_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            sync1_q <= phase_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            cnt_q   <= cnt_d;
            pat_q   <= sync2_q;
            acc_q   <= hit && (sync2_q != last_q);
            if (hit)
                last_q <= sync2_q;
        end
    end

    assign acc_valid_o   = acc_q;
    assign acc_pattern_o = pat_q;
endmodule

// File: rtl/step_phase_decoder.sv
// Decodes filtered coil-phase patterns into steps, direction and a
// half-step position; flags illegal patterns and ambiguous jumps.
//   state       | meaning
//   ST_UNLOCKED | no reference; next legal pattern becomes the reference
//   ST_LOCKED   | reference held; legal patterns counted as steps
module step_phase_decoder #(
    parameter int STABLE_CYC = 5,
    parameter int POS_W      = 16
) (
    input logic                clk,
    input logic                rst,
    step_phase_decoder_if.slave bus
);
    import step_phase_decoder_pkg::*;

    logic             acc_valid;
    logic [3:0]       acc_pattern;
    logic             dec_legal;
    logic [2:0]       dec_idx, delta;
    state_t           state_q, state_d;
    logic [2:0]       ref_q, ref_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d, step_q, step_d, err_q, err_d, sticky_q;

    phase_sync_filter #(.STABLE_CYC(STABLE_CYC)) u_filter (
        .clk           (clk),
        .rst           (rst),
        .phase_i       (bus.phase_in),
        .acc_valid_o   (acc_valid),
        .acc_pattern_o (acc_pattern)
    );

    always_comb begin
        dec_legal = 1'b0;
        dec_idx   = '0;
        for (int i = 0; i < 8; i++) begin
            if (acc_pattern == idx_to_phase(3'(i))) begin
                dec_legal = 1'b1;
                dec_idx   = 3'(i);
            end
        end
    end

    // delta is mod 8; 1,2 forward, 6,7 reverse, anything else is a bad jump.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        step_d  = 1'b0;
        err_d   = 1'b0;
        delta   = dec_idx - ref_q;
        if (acc_valid) begin
            if (acc_pattern == PHASE_IDLE) begin
                state_d = ST_UNLOCKED;
            end else if (!dec_legal) begin
                err_d   = 1'b1;
                state_d = ST_UNLOCKED;
            end else if (state_q == ST_UNLOCKED) begin
                state_d = ST_LOCKED;
                ref_d   = dec_idx;
            end else begin
                case (delta)
                    3'd1, 3'd2, 3'd6, 3'd7: begin
                        step_d = 1'b1;
                        dir_d  = ~delta[2];
                        ref_d  = dec_idx;
                        pos_d  = pos_q + {{(POS_W-3){delta[2]}}, delta};
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_UNLOCKED;
                    end
                endcase
            end
        end
        if (bus.clr_pos)
            pos_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_UNLOCKED;
            ref_q    <= '0;
            pos_q    <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ref_q    <= ref_d;
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            sticky_q <= sticky_q | err_d;
        end
    end

    assign bus.step_pulse = step_q;
    assign bus.dir        = dir_q;
    assign bus.position   = pos_q;
    assign bus.locked     = (state_q == ST_LOCKED);
    assign bus.err_pulse  = err_q;
    assign bus.err_sticky = sticky_q;
endmodule

// File: tb/tb_step_phase_decoder.sv
// Directed bench for step_phase_decoder: 16-bit and 4-bit position instances
// share one stimulus and are checked every cycle against a history-based model.
`timescale 1ns/1ps
module tb_step_phase_decoder;
    localparam int S = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] phase = 4'b0000;
    logic       clr = 1'b0;

    always #5 clk = ~clk;

    step_phase_decoder_if #(.POS_W(16)) bus16 ();
    step_phase_decoder_if #(.POS_W(4))  bus4  ();

    assign bus16.phase_in = phase;
    assign bus16.clr_pos  = clr;
    assign bus4.phase_in  = phase;
    assign bus4.clr_pos   = clr;

    step_phase_decoder #(.STABLE_CYC(S), .POS_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    step_phase_decoder #(.STABLE_CYC(S), .POS_W(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_drive = 0;
    int n_steps = 0, n_errs = 0, last_step_cyc = 0;

    int TBL [8] = '{1, 3, 2, 6, 4, 12, 8, 9};
    int ph_h [$];
    int s_h [$];
    bit acc_v;
    int acc_p, last_acc;
    bit m_locked, m_dir, m_step, m_err, m_sticky;
    int m_ref, m_pos;

    function automatic int idx_of(input int p);
        for (int i = 0; i < 8; i++)
            if (TBL[i] == p) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Model: outputs at edge n follow the acceptance made at edge n-1, which
    // needs exactly S trailing equal synchronised samples (2 edges late).
    always @(posedge clk) begin
        int s_n, run, idx, d;
        logic [20:0] exp16, got16;
        logic [8:0]  exp4, got4;
        cyc++;
        if (rst) begin
            ph_h.delete(); s_h.delete();
            acc_v = 0; acc_p = 0; last_acc = 0;
            m_locked = 0; m_dir = 0; m_step = 0; m_err = 0; m_sticky = 0;
            m_ref = 0; m_pos = 0;
        end else begin
            m_step = 0;
            m_err  = 0;
            if (acc_v) begin
                idx = idx_of(acc_p);
                if (acc_p == 0) m_locked = 0;
                else if (idx < 0) begin m_err = 1; m_locked = 0; end
                else if (!m_locked) begin m_locked = 1; m_ref = idx; end
                else begin
                    d = (idx - m_ref + 8) % 8;
                    if (d == 1 || d == 2) begin
                        m_step = 1; m_dir = 1; m_pos += d; m_ref = idx;
                    end else if (d == 6 || d == 7) begin
                        m_step = 1; m_dir = 0; m_pos -= 8 - d; m_ref = idx;
                    end else begin
                        m_err = 1; m_locked = 0;
                    end
                end
            end
            if (clr) m_pos = 0;
            if (m_err) m_sticky = 1;
            ph_h.push_back(int'(phase));
            s_n = (ph_h.size() >= 3) ? ph_h[ph_h.size()-3] : 0;
            s_h.push_back(s_n);
            run = 0;
            for (int k = s_h.size() - 1; k >= 0 && s_h[k] == s_n && run <= S; k--)
                run++;
            acc_v = (run == S) && (s_n != last_acc);
            if (acc_v) begin acc_p = s_n; last_acc = s_n; end
        end
        #1;
        exp16 = {m_step, m_dir, m_locked, m_err, m_sticky, m_pos[15:0]};
        got16 = {bus16.step_pulse, bus16.dir, bus16.locked, bus16.err_pulse,
                 bus16.err_sticky, bus16.position};
        exp4  = {m_step, m_dir, m_locked, m_err, m_sticky, m_pos[3:0]};
        got4  = {bus4.step_pulse, bus4.dir, bus4.locked, bus4.err_pulse,
                 bus4.err_sticky, bus4.position};
        checks++;
        if (got16 !== exp16) begin
            errors++;
            $display("FAIL model16 cyc %0d got step/dir/lock/err/stk/pos=%b expected %b", cyc, got16, exp16);
        end
        checks++;
        if (got4 !== exp4) begin
            errors++;
            $display("FAIL model4 cyc %0d got step/dir/lock/err/stk/pos=%b expected %b", cyc, got4, exp4);
        end
        if (bus16.step_pulse) begin n_steps++; last_step_cyc = cyc; end
        if (bus16.err_pulse) n_errs++;
    end

    // Called at a negedge; returns at a negedge n cycles later.
    task automatic hold(input logic [3:0] p, input int n);
        phase   = p;
        t_drive = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        logic [3:0] t2 [4];
        logic [3:0] hs [7];
        int base, ebase;
        t2 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        hs = '{4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};

        // T1 reset with toggling input, then first pattern only locks
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            phase = (i % 2 == 1) ? 4'b0001 : 4'b0110;
            @(negedge clk);
        end
        chk("t1_reset_outputs", int'({bus16.step_pulse, bus16.dir, bus16.locked,
            bus16.err_pulse, bus16.err_sticky, bus16.position}), 0);
        rst = 1'b0;
        hold(4'b0001, 12);
        chk("t1_locked", int'(bus16.locked), 1);
        chk("t1_no_step", n_steps, 0);

        // T2 full-step forward, 8-edge latency per pulse
        base = n_steps;
        for (int i = 0; i < 4; i++) begin
            hold(t2[i], 10);
            chk("t2_latency", last_step_cyc - t_drive, 8);
        end
        chk("t2_steps", n_steps - base, 4);
        chk("t2_dir", int'(bus16.dir), 1);
        chk("t2_pos", int'(bus16.position), 8);

        // T3 half-step reverse from a cleared position
        pulse_clr();
        base = n_steps;
        hold(4'b1001, 10);
        hold(4'b1000, 10);
        hold(4'b1100, 10);
        chk("t3_steps", n_steps - base, 3);
        chk("t3_dir", int'(bus16.dir), 0);
        chk("t3_pos", int'(bus16.position), 16'hFFFD);

        // T4 short glitch ignored
        hold(4'b0000, 10);
        hold(4'b0001, 10);
        base = n_steps;
        hold(4'b0010, 4);
        hold(4'b0001, 10);
        chk("t4_no_step", n_steps - base, 0);
        chk("t4_pos", int'(bus16.position), 16'hFFFD);
        chk("t4_locked", int'(bus16.locked), 1);

        // T5 illegal pattern, then ambiguous d=4 jump
        ebase = n_errs;
        hold(4'b0101, 10);
        chk("t5_err_once", n_errs - ebase, 1);
        chk("t5_sticky", int'(bus16.err_sticky), 1);
        chk("t5_unlocked", int'(bus16.locked), 0);
        hold(4'b0001, 10);
        chk("t5_relock", int'(bus16.locked), 1);
        hold(4'b0100, 10);
        chk("t5_err_jump", n_errs - ebase, 2);
        chk("t5_pos_held", int'(bus16.position), 16'hFFFD);
        chk("t5_unlocked2", int'(bus16.locked), 0);

        // T6 wrap on the 4-bit instance, clear coincident with a step
        pulse_clr();
        hold(4'b0001, 10);
        for (int i = 0; i < 7; i++) hold(hs[i], 10);
        chk("t6_pos4_7", int'(bus4.position), 7);
        hold(4'b0001, 10);
        chk("t6_pos4_wrap", int'(bus4.position), 4'b1000);
        chk("t6_pos16", int'(bus16.position), 8);
        phase = 4'b0011;
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_clr_step", int'(bus16.step_pulse), 1);
        chk("t6_clr_pos16", int'(bus16.position), 0);
        chk("t6_clr_pos4", int'(bus4.position), 0);
        @(negedge clk);
        clr = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-filter, then re-lock without a step
        phase = 4'b0010;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_mid_outputs", int'({bus16.step_pulse, bus16.dir, bus16.locked,
            bus16.err_pulse, bus16.err_sticky, bus16.position}), 0);
        rst = 1'b0;
        base = n_steps;
        repeat (12) @(negedge clk);
        chk("rst_relock", int'(bus16.locked), 1);
        chk("rst_no_step", n_steps - base, 0);
        chk("rst_pos", int'(bus16.position), 0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
